// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional memory-wait watchdog is compiled in with `define MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM   = 3'd4, S_WB     = 3'd5,
                         S_TRAP = 3'd6;

  localparam logic [6:0] OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                         OP_LD   = 7'b0000011, OP_ST    = 7'b0100011,
                         OP_BR   = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_AND = 4'b0010,
                         A_OR  = 4'b0011, A_XOR = 4'b0100, A_SLL = 4'b0101,
                         A_SRL = 4'b0110, A_SRA = 4'b0111, A_SLT = 4'b1000,
                         A_SLTU = 4'b1001;

  logic [2:0] state_nx;
  logic [2:0] end_st;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic       is_jump, legal, alt;
  logic [3:0] func_op;
  logic       to_hit;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jump  = is_jal | is_jalr;
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jump | is_lui | is_auipc;
  assign alt      = (funct7 == 7'b0100000);
  assign end_st   = run ? S_FETCH : S_IDLE;

  // funct7 only matters for SUB (R-type) and the arithmetic right shifts
  always_comb begin
    func_op = A_ADD;
    case (funct3)
      3'b000:  func_op = (is_r && alt) ? A_SUB : A_ADD;
      3'b001:  func_op = A_SLL;
      3'b010:  func_op = A_SLT;
      3'b011:  func_op = A_SLTU;
      3'b100:  func_op = A_XOR;
      3'b101:  func_op = alt ? A_SRA : A_SRL;
      3'b110:  func_op = A_OR;
      default: func_op = A_AND;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [TO_W-1:0] wait_cnt;

  // Limit reached only on a cycle still waiting; a same-cycle mem_ready completes.
  assign to_hit = mem_req && !mem_ready && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state_nx != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + TO_W'(1);
      if (to_hit)
        timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE && !legal)
        illegal <= 1'b1;
      // pc_write is asserted exactly once per retiring instruction
      if (pc_write)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH:  begin
        if (mem_ready)   state_nx = S_DECODE;
        else if (to_hit) state_nx = S_TRAP;
      end
      S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_br)                                       state_nx = end_st;
        else if (is_ld || is_st)                         state_nx = S_MEM;
        else if (is_r || is_i || is_lui || is_auipc || is_jump) state_nx = S_WB;
        else                                             state_nx = S_TRAP;
      end
      S_MEM: begin
        if (mem_ready)   state_nx = is_ld ? S_WB : end_st;
        else if (to_hit) state_nx = S_TRAP;
      end
      S_WB:     state_nx = end_st;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    alu_op       = A_ADD;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      S_EXEC: begin
        if (is_r) begin
          alu_op = func_op;
        end else if (is_i) begin
          alu_src_b = 2'd1;
          alu_op    = func_op;
        end else if (is_lui) begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
        end else if (is_auipc || is_jal) begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
        end else if (is_ld || is_st || is_jalr) begin
          alu_src_b = 2'd1;
        end else if (is_br) begin
          alu_op   = A_SUB;
          pc_write = 1'b1;
          pc_src   = branch_cond ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        pc_write     = is_st && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = is_ld ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        pc_src    = is_jump ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, we, asel, irw, pcw;
    logic [1:0]  pcs, sa, sb;
    logic [3:0]  op;
    logic        rw;
    logic [1:0]  wbs;
    logic        ill, to;
    logic [31:0] ir;
  } ctl_t;

  logic        clk, rst_n, run, branch_cond, mem_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
  logic        illegal, timeout;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_ctrl #(.CNT_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
    .timeout(timeout), .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    tests = 0, fails = 0;

  int         n = 0;
  logic       ill_e = 1'b0, to_e = 1'b0;
  logic       rst_q = 1'b0, run_q = 1'b0;
  logic [6:0] op_q = 7'd0, f7_q = 7'd0;
  logic [2:0] f3_q = 3'd0;

  // Monitor: each negedge with a pending expectation is one comparison
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{st: state, req: mem_req, we: mem_we, asel: mem_addr_sel,
            irw: ir_write, pcw: pc_write, pcs: pc_src, sa: alu_src_a,
            sb: alu_src_b, op: alu_op, rw: reg_write, wbs: wb_sel,
            ill: illegal, to: timeout, ir: instret};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: actual %h required %h", t, a, e);
      end
    end
  end

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t b;
    b = '0;
    b.st = st; b.ir = n; b.ill = ill_e; b.to = to_e;
    return b;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t b;
    b = base(3'd1); b.req = 1'b1; b.irw = rdy;
    return b;
  endfunction

  function automatic ctl_t e_dec();
    ctl_t b;
    b = base(3'd2); b.sa = 2'd1; b.sb = 2'd1;
    return b;
  endfunction

  function automatic ctl_t e_exe(input logic [1:0] sa, sb, input logic [3:0] op,
                                 input logic pcw, input logic [1:0] pcs);
    ctl_t b;
    b = base(3'd3); b.sa = sa; b.sb = sb; b.op = op; b.pcw = pcw; b.pcs = pcs;
    return b;
  endfunction

  function automatic ctl_t e_mem(input logic we, rdy);
    ctl_t b;
    b = base(3'd4); b.req = 1'b1; b.asel = 1'b1; b.we = we; b.pcw = we & rdy;
    return b;
  endfunction

  function automatic ctl_t e_wb(input logic [1:0] wbs, pcs);
    ctl_t b;
    b = base(3'd5); b.rw = 1'b1; b.pcw = 1'b1; b.wbs = wbs; b.pcs = pcs;
    return b;
  endfunction

  // Advance one cycle: apply inputs just after the edge, queue that cycle's expectation
  task automatic cyc(input logic rdy, bc, input string tag, input ctl_t e);
    @(posedge clk); #1;
    rst_n = rst_q; run = run_q; mem_ready = rdy; branch_cond = bc;
    opcode = op_q; funct3 = f3_q; funct7 = f7_q;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic fetch(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input int waits, input string tag);
    op_q = o; f3_q = f3; f7_q = f7;
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, {tag, "_fwait"}, e_fetch(1'b0));
    cyc(1'b1, 1'b0, {tag, "_fetch"}, e_fetch(1'b1));
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [1:0] sa, sb, input logic [3:0] op,
                           input logic [1:0] wbs, pcs, input string tag);
    fetch(o, f3, f7, 0, tag);
    cyc(1'b1, 1'b0, {tag, "_dec"}, e_dec());
    cyc(1'b1, 1'b1, {tag, "_exec"}, e_exe(sa, sb, op, 1'b0, 2'd0));
    cyc(1'b0, 1'b0, {tag, "_wb"}, e_wb(wbs, pcs));
    n++;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;

    cyc(1'b0, 1'b0, "reset", base(3'd0));
    rst_q = 1'b1;
    cyc(1'b0, 1'b0, "idle", base(3'd0));
    run_q = 1'b1;
    cyc(1'b0, 1'b0, "idle_run", base(3'd0));

    alu_instr(7'b0110011, 3'b000, 7'b0100000, 2'd0, 2'd0, 4'b0001, 2'd0, 2'd0, "sub");
    alu_instr(7'b0010011, 3'b101, 7'b0100000, 2'd0, 2'd1, 4'b0111, 2'd0, 2'd0, "srai");
    alu_instr(7'b0010011, 3'b101, 7'b0000000, 2'd0, 2'd1, 4'b0110, 2'd0, 2'd0, "srli");
    alu_instr(7'b0110011, 3'b111, 7'b0000000, 2'd0, 2'd0, 4'b0010, 2'd0, 2'd0, "and");
    alu_instr(7'b0110011, 3'b011, 7'b0000000, 2'd0, 2'd0, 4'b1001, 2'd0, 2'd0, "sltu");
    alu_instr(7'b0010011, 3'b000, 7'b0100000, 2'd0, 2'd1, 4'b0000, 2'd0, 2'd0, "addi");
    alu_instr(7'b0110111, 3'b000, 7'b0000000, 2'd2, 2'd1, 4'b0000, 2'd0, 2'd0, "lui");
    alu_instr(7'b0010111, 3'b000, 7'b0000000, 2'd1, 2'd1, 4'b0000, 2'd0, 2'd0, "auipc");
    alu_instr(7'b1101111, 3'b000, 7'b0000000, 2'd1, 2'd1, 4'b0000, 2'd2, 2'd2, "jal");
    alu_instr(7'b1100111, 3'b000, 7'b0000000, 2'd0, 2'd1, 4'b0000, 2'd2, 2'd2, "jalr");

    // Load: one fetch wait, three MEM waits
    fetch(7'b0000011, 3'b010, 7'b0, 1, "lw");
    cyc(1'b0, 1'b0, "lw_dec", e_dec());
    cyc(1'b0, 1'b0, "lw_exec", e_exe(2'd0, 2'd1, 4'b0000, 1'b0, 2'd0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "lw_mwait", e_mem(1'b0, 1'b0));
    cyc(1'b1, 1'b0, "lw_mem", e_mem(1'b0, 1'b1));
    cyc(1'b0, 1'b0, "lw_wb", e_wb(2'd1, 2'd0));
    n++;

    // Store retires in MEM
    fetch(7'b0100011, 3'b010, 7'b0, 0, "sw");
    cyc(1'b1, 1'b0, "sw_dec", e_dec());
    cyc(1'b1, 1'b0, "sw_exec", e_exe(2'd0, 2'd1, 4'b0000, 1'b0, 2'd0));
    cyc(1'b0, 1'b0, "sw_mwait", e_mem(1'b1, 1'b0));
    cyc(1'b1, 1'b0, "sw_mem", e_mem(1'b1, 1'b1));
    n++;

    fetch(7'b1100011, 3'b000, 7'b0, 0, "beq_t");
    cyc(1'b1, 1'b1, "beq_t_dec", e_dec());
    cyc(1'b1, 1'b1, "beq_t_exec", e_exe(2'd0, 2'd0, 4'b0001, 1'b1, 2'd1));
    n++;

    // run drops mid-instruction: branch still completes, then IDLE
    fetch(7'b1100011, 3'b001, 7'b0, 0, "bne_nt");
    run_q = 1'b0;
    cyc(1'b1, 1'b0, "bne_nt_dec", e_dec());
    cyc(1'b1, 1'b0, "bne_nt_exec", e_exe(2'd0, 2'd0, 4'b0001, 1'b1, 2'd0));
    n++;
    cyc(1'b1, 1'b0, "end_idle", base(3'd0));
    cyc(1'b1, 1'b0, "end_idle2", base(3'd0));

    // Reset asserted while a load waits in MEM
    run_q = 1'b1;
    cyc(1'b0, 1'b0, "rst_idle", base(3'd0));
    fetch(7'b0000011, 3'b000, 7'b0, 0, "rlw");
    cyc(1'b0, 1'b0, "rlw_dec", e_dec());
    cyc(1'b0, 1'b0, "rlw_exec", e_exe(2'd0, 2'd1, 4'b0000, 1'b0, 2'd0));
    cyc(1'b0, 1'b0, "rlw_mwait", e_mem(1'b0, 1'b0));
    rst_q = 1'b0; n = 0;
    cyc(1'b0, 1'b0, "rst_mid_mem", base(3'd0));
    rst_q = 1'b1; run_q = 1'b0;
    cyc(1'b0, 1'b0, "rst_release", base(3'd0));

    // Illegal opcode traps and stays put
    run_q = 1'b1;
    cyc(1'b0, 1'b0, "ill_idle", base(3'd0));
    fetch(7'b1111111, 3'b000, 7'b0, 0, "ill");
    cyc(1'b1, 1'b1, "ill_dec", e_dec());
    ill_e = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, "ill_trap", base(3'd6));
    rst_q = 1'b0; ill_e = 1'b0; run_q = 1'b0;
    cyc(1'b0, 1'b0, "ill_reset", base(3'd0));
    rst_q = 1'b1;
    cyc(1'b0, 1'b0, "ill_release", base(3'd0));

    run_q = 1'b1;
    cyc(1'b0, 1'b0, "to_idle", base(3'd0));
`ifdef MEM_TIMEOUT_EN
    op_q = 7'b0110011; f3_q = 3'b000; f7_q = 7'b0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, "to_wait", e_fetch(1'b0));
    to_e = 1'b1;
    cyc(1'b0, 1'b0, "to_trap", base(3'd6));
    rst_q = 1'b0; to_e = 1'b0;
    cyc(1'b0, 1'b0, "to_reset", base(3'd0));
    rst_q = 1'b1;
    cyc(1'b0, 1'b0, "to_idle2", base(3'd0));
    fetch(7'b0110011, 3'b000, 7'b0, 7, "to_edge");
    cyc(1'b1, 1'b0, "to_edge_dec", e_dec());
    cyc(1'b1, 1'b0, "to_edge_exec", e_exe(2'd0, 2'd0, 4'b0000, 1'b0, 2'd0));
    cyc(1'b0, 1'b0, "to_edge_wb", e_wb(2'd0, 2'd0));
    n++;
`else
    fetch(7'b0110011, 3'b100, 7'b0, 12, "longwait");
    cyc(1'b1, 1'b0, "longwait_dec", e_dec());
    cyc(1'b1, 1'b0, "longwait_exec", e_exe(2'd0, 2'd0, 4'b0100, 1'b0, 2'd0));
    cyc(1'b0, 1'b0, "longwait_wb", e_wb(2'd0, 2'd0));
    n++;
`endif
    run_q = 1'b0;
    cyc(1'b0, 1'b0, "final_fetch", e_fetch(1'b0));
    cyc(1'b1, 1'b0, "final_fetch2", e_fetch(1'b1));
    cyc(1'b0, 1'b0, "final_dec", e_dec());

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
